// File: rtl/bcd_time_pkg.sv
// Shared encodings and the two-digit BCD type for the alarm clock time keeper.
// No logic; no latency; no backpressure.
package bcd_time_pkg;

    typedef enum logic [1:0] {
        MODE_RUN       = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_ALARM = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        FIELD_HOUR = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_SEC  = 2'd2
    } field_t;

    localparam int HOUR_MAX = 23;
    localparam int MIN_MAX  = 59;
    localparam int SEC_MAX  = 59;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd2_t;

    function automatic bcd2_t to_bcd2(input int unsigned v);
        bcd2_t r;
        r.tens  = 4'(v / 10);
        r.units = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping MAX_VAL -> 00; carry flags an increment that wraps.
// Latency: value updates on the edge where inc is high. Backpressure: none, inc always accepted.
module bcd_wrap_counter
    import bcd_time_pkg::*;
#(
    parameter int MAX_VAL = 59
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  inc,
    output bcd2_t value,
    output logic  carry
);

    localparam bcd2_t MAX_BCD = to_bcd2(MAX_VAL);

    assign carry = inc && (value == MAX_BCD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (inc) begin
            if (value == MAX_BCD) begin
                value <= '0;
            end else if (value.units == 4'd9) begin
                value.tens  <= value.tens + 4'd1;
                value.units <= 4'd0;
            end else begin
                value.units <= value.units + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_time_keeper.sv
// Time-of-day and alarm keeper producing hh:mm:ss BCD digits, mode/field state and a timed alarm.
// Latency: internal state moves on the tick/key edge, digit outputs one cycle later. Backpressure: none.
module bcd_time_keeper
    import bcd_time_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int ALARM_SECS = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_key,
    input  logic       sel_key,
    input  logic       inc_key,
    input  logic       alarm_ack,
    output logic [3:0] data5,
    output logic [3:0] data4,
    output logic [3:0] data3,
    output logic [3:0] data2,
    output logic [3:0] data1,
    output logic [3:0] data0,
    output logic       sec_tick,
    output logic [1:0] mode,
    output logic [1:0] field_sel,
    output logic       alarm_on
);

    localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int RW = ($clog2(ALARM_SECS + 1) > 0) ? $clog2(ALARM_SECS + 1) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);
    localparam logic [RW-1:0] RING_LOAD = RW'(ALARM_SECS);

    mode_t         mode_q, mode_d;
    field_t        field_q, field_d;
    logic [PW-1:0] presc_q;
    logic [RW-1:0] ring_q;
    logic          armed_q;
    logic          tick_now, inc_act, set_time, set_alarm, ring_start;

    bcd2_t t_hr, t_min, t_sec, a_hr, a_min, a_sec;
    bcd2_t src_hr, src_min, src_sec;
    logic  t_sec_c, t_min_c, t_hr_c, a_hr_c, a_min_c, a_sec_c;
    logic  unused_carry;

    assign set_time  = (mode_q == MODE_SET_TIME);
    assign set_alarm = (mode_q == MODE_SET_ALARM);

    // Only the highest-priority key acts; sel/inc do nothing in RUN.
    always_comb begin
        mode_d  = mode_q;
        field_d = field_q;
        inc_act = 1'b0;
        if (mode_key) begin
            field_d = FIELD_HOUR;
            case (mode_q)
                MODE_RUN:      mode_d = MODE_SET_TIME;
                MODE_SET_TIME: mode_d = MODE_SET_ALARM;
                default:       mode_d = MODE_RUN;
            endcase
        end else if (mode_q != MODE_RUN) begin
            if (sel_key) begin
                case (field_q)
                    FIELD_HOUR: field_d = FIELD_MIN;
                    FIELD_MIN:  field_d = FIELD_SEC;
                    default:    field_d = FIELD_HOUR;
                endcase
            end else if (inc_key) begin
                inc_act = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_RUN;
            field_q <= FIELD_HOUR;
            armed_q <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            field_q <= field_d;
            if (mode_key && set_alarm)
                armed_q <= 1'b1;
        end
    end

    // Prescaler is parked at 0 while setting time so the next second starts whole.
    assign tick_now = !set_time && (presc_q == PRESC_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            presc_q <= '0;
        else if (set_time || mode_d == MODE_SET_TIME || presc_q == PRESC_MAX)
            presc_q <= '0;
        else
            presc_q <= presc_q + PW'(1);
    end

    // Carries chain only on the real tick; key increments never ripple.
    bcd_wrap_counter #(.MAX_VAL(SEC_MAX)) u_t_sec (
        .clk(clk), .rst(rst),
        .inc(tick_now || (inc_act && set_time && field_q == FIELD_SEC)),
        .value(t_sec), .carry(t_sec_c)
    );
    bcd_wrap_counter #(.MAX_VAL(MIN_MAX)) u_t_min (
        .clk(clk), .rst(rst),
        .inc((tick_now && t_sec_c) || (inc_act && set_time && field_q == FIELD_MIN)),
        .value(t_min), .carry(t_min_c)
    );
    bcd_wrap_counter #(.MAX_VAL(HOUR_MAX)) u_t_hr (
        .clk(clk), .rst(rst),
        .inc((tick_now && t_min_c) || (inc_act && set_time && field_q == FIELD_HOUR)),
        .value(t_hr), .carry(t_hr_c)
    );

    bcd_wrap_counter #(.MAX_VAL(SEC_MAX)) u_a_sec (
        .clk(clk), .rst(rst),
        .inc(inc_act && set_alarm && field_q == FIELD_SEC),
        .value(a_sec), .carry(a_sec_c)
    );
    bcd_wrap_counter #(.MAX_VAL(MIN_MAX)) u_a_min (
        .clk(clk), .rst(rst),
        .inc(inc_act && set_alarm && field_q == FIELD_MIN),
        .value(a_min), .carry(a_min_c)
    );
    bcd_wrap_counter #(.MAX_VAL(HOUR_MAX)) u_a_hr (
        .clk(clk), .rst(rst),
        .inc(inc_act && set_alarm && field_q == FIELD_HOUR),
        .value(a_hr), .carry(a_hr_c)
    );

    assign unused_carry = ^{t_hr_c, a_hr_c, a_min_c, a_sec_c};

    // sec_tick is high the cycle after the counters advanced, so the compare sees the new time.
    assign ring_start = sec_tick && armed_q && !set_time
                        && ({t_hr, t_min, t_sec} == {a_hr, a_min, a_sec});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_on <= 1'b0;
            ring_q   <= '0;
        end else if (alarm_ack) begin
            alarm_on <= 1'b0;
            ring_q   <= '0;
        end else if (ring_start) begin
            alarm_on <= 1'b1;
            ring_q   <= RING_LOAD;
        end else if (sec_tick && alarm_on) begin
            if (ring_q <= RW'(1)) begin
                alarm_on <= 1'b0;
                ring_q   <= '0;
            end else begin
                ring_q <= ring_q - RW'(1);
            end
        end
    end

    assign src_hr  = set_alarm ? a_hr  : t_hr;
    assign src_min = set_alarm ? a_min : t_min;
    assign src_sec = set_alarm ? a_sec : t_sec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick <= 1'b0;
            data5    <= 4'd0;
            data4    <= 4'd0;
            data3    <= 4'd0;
            data2    <= 4'd0;
            data1    <= 4'd0;
            data0    <= 4'd0;
        end else begin
            sec_tick <= tick_now;
            data5    <= src_hr.tens;
            data4    <= src_hr.units;
            data3    <= src_min.tens;
            data2    <= src_min.units;
            data1    <= src_sec.tens;
            data0    <= src_sec.units;
        end
    end

    assign mode      = mode_q;
    assign field_sel = field_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Directed and randomized checks of bcd_time_keeper against a seconds-based reference model.
module tb_bcd_time_keeper;

    localparam int CF = 4;
    localparam int AS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       mode_key = 1'b0, sel_key = 1'b0, inc_key = 1'b0, alarm_ack = 1'b0;
    logic [3:0] data5, data4, data3, data2, data1, data0;
    logic       sec_tick, alarm_on;
    logic [1:0] mode, field_sel;

    always #5 clk = ~clk;

    bcd_time_keeper #(.CLK_FREQ(CF), .ALARM_SECS(AS)) dut (
        .clk(clk), .rst(rst),
        .mode_key(mode_key), .sel_key(sel_key), .inc_key(inc_key), .alarm_ack(alarm_ack),
        .data5(data5), .data4(data4), .data3(data3), .data2(data2), .data1(data1), .data0(data0),
        .sec_tick(sec_tick), .mode(mode), .field_sel(field_sel), .alarm_on(alarm_on)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: plain integers for time, alarm, mode and ring bookkeeping.
    int m_mode, m_field, m_presc, m_h, m_m, m_s, a_h, a_m, a_s;
    int m_armed, m_ring, m_on, m_tick, d_h, d_m, d_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_field = 0; m_presc = 0;
        m_h = 0; m_m = 0; m_s = 0; a_h = 0; a_m = 0; a_s = 0;
        m_armed = 0; m_ring = 0; m_on = 0; m_tick = 0;
        d_h = 0; d_m = 0; d_s = 0;
    endtask

    task automatic model_edge(input bit mk, input bit sk, input bit ik, input bit ak);
        int  nmode, tsec;
        bit  tick_now, sel_e, inc_e, match;
        if (m_mode == 2) begin d_h = a_h; d_m = a_m; d_s = a_s; end
        else             begin d_h = m_h; d_m = m_m; d_s = m_s; end
        match = (m_tick == 1) && (m_armed == 1) && (m_mode != 1)
                && (m_h == a_h) && (m_m == a_m) && (m_s == a_s);
        if (ak) begin
            m_on = 0; m_ring = 0;
        end else if (match) begin
            m_on = 1; m_ring = AS;
        end else if (m_tick == 1 && m_on == 1) begin
            m_ring--;
            if (m_ring <= 0) begin m_on = 0; m_ring = 0; end
        end
        tick_now = (m_mode != 1) && (m_presc == CF - 1);
        sel_e = sk && !mk && (m_mode != 0);
        inc_e = ik && !mk && !sk && (m_mode != 0);
        if (tick_now) begin
            tsec = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
            m_h = tsec / 3600; m_m = (tsec / 60) % 60; m_s = tsec % 60;
        end
        if (inc_e && m_mode == 1) begin
            if (m_field == 0)      m_h = (m_h + 1) % 24;
            else if (m_field == 1) m_m = (m_m + 1) % 60;
            else                   m_s = (m_s + 1) % 60;
        end
        if (inc_e && m_mode == 2) begin
            if (m_field == 0)      a_h = (a_h + 1) % 24;
            else if (m_field == 1) a_m = (a_m + 1) % 60;
            else                   a_s = (a_s + 1) % 60;
        end
        if (mk && m_mode == 2) m_armed = 1;
        nmode = mk ? (m_mode + 1) % 3 : m_mode;
        m_presc = (m_mode == 1 || nmode == 1) ? 0 : (m_presc + 1) % CF;
        if (mk)         m_field = 0;
        else if (sel_e) m_field = (m_field + 1) % 3;
        m_mode = nmode;
        m_tick = tick_now ? 1 : 0;
    endtask

    task automatic check_all();
        chk("data5", data5, d_h / 10);
        chk("data4", data4, d_h % 10);
        chk("data3", data3, d_m / 10);
        chk("data2", data2, d_m % 10);
        chk("data1", data1, d_s / 10);
        chk("data0", data0, d_s % 10);
        chk("sec_tick", sec_tick, m_tick);
        chk("mode", mode, m_mode);
        chk("field_sel", field_sel, m_field);
        chk("alarm_on", alarm_on, m_on);
    endtask

    task automatic chk_digits(input string tag, input int h, input int m, input int s);
        chk({tag, "_h"}, {data5, data4}, {4'(h / 10), 4'(h % 10)});
        chk({tag, "_m"}, {data3, data2}, {4'(m / 10), 4'(m % 10)});
        chk({tag, "_s"}, {data1, data0}, {4'(s / 10), 4'(s % 10)});
    endtask

    task automatic step(input bit mk, input bit sk, input bit ik, input bit ak);
        mode_key = mk; sel_key = sk; inc_key = ik; alarm_ack = ak;
        @(posedge clk);
        model_edge(mk, sk, ik, ak);
        #1;
        mode_key = 1'b0; sel_key = 1'b0; inc_key = 1'b0; alarm_ack = 1'b0;
        check_all();
    endtask

    // which: 0 = mode_key, 1 = sel_key, 2 = inc_key
    task automatic press(input int which, input int n);
        for (int i = 0; i < n; i++) step(which == 0, which == 1, which == 2, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (sec_tick !== 1'b1 && n < 40);
        chk("tick_wait", sec_tick, 1);
    endtask

    task automatic wait_alarm();
        int n;
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (alarm_on !== 1'b1 && n < 200);
        chk("alarm_wait", alarm_on, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // From reset: alarm 00:00:05, armed, back in RUN.
    task automatic setup_alarm5();
        press(0, 2);
        press(1, 2);
        press(2, 5);
        press(0, 1);
    endtask

    initial begin
        int n, nt, rose;
        bit mk, sk, ik, ak;
        model_reset();
        #1 rst = 1'b1;
        #2;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // mode_key beats inc_key in the same cycle
        step(1'b1, 1'b0, 1'b1, 1'b0);
        chk("prio_mode", mode, 1);
        chk("prio_field", field_sel, 0);

        // Hour wraps 23 -> 00 without touching minutes; minute wraps without carry
        press(2, 25);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk_digits("set_hour", 1, 0, 0);
        press(2, 60);
        idle(1);
        chk_digits("set_min", 1, 0, 0);
        chk("set_no_tick", sec_tick, 0);

        // Preload 23:59:58 and run through midnight
        press(2, 59);
        press(1, 1);
        press(2, 58);
        press(1, 1);
        press(2, 22);
        press(0, 2);
        wait_tick(n);
        idle(1);
        chk_digits("wrap1", 23, 59, 59);
        wait_tick(n);
        chk("tick_period1", n + 1, CF);
        idle(1);
        chk_digits("wrap2", 0, 0, 0);
        chk("alarm_midnight", alarm_on, 1);
        wait_tick(n);
        chk("tick_period2", n + 1, CF);
        idle(1);
        chk_digits("wrap3", 0, 0, 1);

        // Ring for ALARM_SECS ticks
        do_reset();
        setup_alarm5();
        wait_alarm();
        chk_digits("ring_rise", 0, 0, 5);
        nt = 0; n = 0;
        while (alarm_on === 1'b1 && n < 60) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
            if (sec_tick === 1'b1) nt++;
        end
        chk("ring_ticks", nt, AS);
        chk("ring_end_sec", data0, 8);

        // Acknowledge one cycle after the rise
        do_reset();
        setup_alarm5();
        wait_alarm();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("ack_clear", alarm_on, 0);

        // Acknowledge coinciding with the match tick
        do_reset();
        setup_alarm5();
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            n++;
        end while (!(sec_tick === 1'b1 && data0 === 4'd4) && n < 60);
        chk("pre_match", data0, 4);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        rose = 0;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (alarm_on !== 1'b0) rose = 1;
        end
        chk("ack_suppress", rose, 0);

        // Reset in the middle of a ring, away from any rising clock edge
        do_reset();
        setup_alarm5();
        wait_alarm();
        do_reset();
        chk("midring_alarm", alarm_on, 0);
        chk_digits("midring", 0, 0, 0);

        // Unarmed: pass through 00:00:00 in SET_ALARM with no ring
        press(0, 1);
        press(2, 23);
        press(1, 1);
        press(2, 59);
        press(1, 1);
        press(2, 59);
        press(0, 1);
        rose = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (alarm_on !== 1'b0) rose = 1;
        end
        chk("disarmed", rose, 0);

        // Random key traffic against the model
        for (int i = 0; i < 1500; i++) begin
            mk = ($urandom_range(0, 19) == 0);
            sk = ($urandom_range(0, 5) == 0);
            ik = ($urandom_range(0, 2) == 0);
            ak = ($urandom_range(0, 39) == 0);
            step(mk, sk, ik, ak);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
